rps_match_ctrl: RTL and testbench



---
 rtl/rps_pkg.sv | 30 +++
 rtl/rps_round_check.sv | 36 +++
 rtl/rps_match_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rps_match_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors match controller slice.
// Holds the winner encodings, the match FSM state encoding, the default
// match parameters and the bit positions of the decoded round outcome.
package rps_pkg;

    // Winner code reported on the winner output.
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Match controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Default match shape: first to three, at most nine rounds.
    localparam int DEF_WINS_NEEDED = 3;
    localparam int DEF_MAX_ROUNDS  = 9;

    // Bit positions inside the one-hot decoded outcome.
    localparam int OUT_A   = 0;
    localparam int OUT_B   = 1;
    localparam int OUT_TIE = 2;

endpackage

// File: rtl/rps_round_check.sv
// Combinational validator for one judged round.
// Ports:
//   player_a_wins, player_b_wins, tie_game : raw judge result bits
//   round_ok : exactly one judge bit is high
//   outcome  : one-hot {tie, b, a}; all zero when the round is malformed
module rps_round_check
    import rps_pkg::*;
(
    input  logic       player_a_wins,
    input  logic       player_b_wins,
    input  logic       tie_game,
    output logic       round_ok,
    output logic [2:0] outcome
);

    logic [2:0] raw_s;

    // Exactly-one-hot test and gated outcome decode.
    always_comb begin
        raw_s          = 3'b000;
        raw_s[OUT_A]   = player_a_wins;
        raw_s[OUT_B]   = player_b_wins;
        raw_s[OUT_TIE] = tie_game;
        case (raw_s)
            3'b001, 3'b010, 3'b100: begin
                round_ok = 1'b1;
                outcome  = raw_s;
            end
            default: begin
                round_ok = 1'b0;
                outcome  = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller. Consumes one judged round per
// round_valid strobe, keeps the running score and declares the winner of a
// first-to-WINS_NEEDED match capped at MAX_ROUNDS rounds (ties count toward
// the cap). Malformed judge results set a sticky error and are discarded.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : pulse, clears and begins a new match (top priority)
//   round_valid        : judge result bits valid this cycle
//   player_a_wins, player_b_wins, tie_game : judge result bits
//   round_ready        : high while a match is in progress
//   score_a, score_b   : rounds won by each player
//   round_count        : accepted rounds, ties included
//   match_over         : match decided
//   winner             : 00 none, 01 A, 10 B, 11 draw (non-zero only when over)
//   result_err         : sticky malformed-round flag for the current match
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int WINS_NEEDED = DEF_WINS_NEEDED,
    parameter int MAX_ROUNDS  = DEF_MAX_ROUNDS,
    parameter int SCORE_W     = 3,
    parameter int RND_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               round_valid,
    input  logic               player_a_wins,
    input  logic               player_b_wins,
    input  logic               tie_game,
    output logic               round_ready,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [RND_W-1:0]   round_count,
    output logic               match_over,
    output logic [1:0]         winner,
    output logic               result_err
);

    localparam logic [SCORE_W-1:0] WINS_TGT  = SCORE_W'(WINS_NEEDED);
    localparam logic [RND_W-1:0]   ROUND_CAP = RND_W'(MAX_ROUNDS);

    state_t             state_r, state_s;
    logic [SCORE_W-1:0] score_a_r, score_a_s;
    logic [SCORE_W-1:0] score_b_r, score_b_s;
    logic [RND_W-1:0]   round_count_r, round_count_s;
    winner_t            winner_r, winner_s;
    logic               result_err_r, result_err_s;
    logic               round_ready_r, round_ready_s;
    logic               match_over_r, match_over_s;

    logic               round_ok_s;
    logic [2:0]         outcome_s;

    rps_round_check u_round_check (
        .player_a_wins (player_a_wins),
        .player_b_wins (player_b_wins),
        .tie_game      (tie_game),
        .round_ok      (round_ok_s),
        .outcome       (outcome_s)
    );

    // Next-state, score update and match-end decision.
    always_comb begin
        state_s       = state_r;
        score_a_s     = score_a_r;
        score_b_s     = score_b_r;
        round_count_s = round_count_r;
        winner_s      = winner_r;
        result_err_s  = result_err_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s       = ST_PLAY;
                    score_a_s     = SCORE_W'(0);
                    score_b_s     = SCORE_W'(0);
                    round_count_s = RND_W'(0);
                    winner_s      = WIN_NONE;
                    result_err_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (start) begin
                    // Restart wins over any round presented in the same cycle.
                    state_s       = ST_PLAY;
                    score_a_s     = SCORE_W'(0);
                    score_b_s     = SCORE_W'(0);
                    round_count_s = RND_W'(0);
                    winner_s      = WIN_NONE;
                    result_err_s  = 1'b0;
                end else if (round_valid && !round_ok_s) begin
                    result_err_s = 1'b1;
                end else if (round_valid) begin
                    case (outcome_s)
                        3'b001:  score_a_s = score_a_r + SCORE_W'(1);
                        3'b010:  score_b_s = score_b_r + SCORE_W'(1);
                        3'b100:  score_a_s = score_a_r;
                        default: score_a_s = score_a_r;
                    endcase
                    round_count_s = round_count_r + RND_W'(1);
                    // A threshold win is checked before the cap so that a
                    // decisive final round reports the player, not the cap.
                    if (score_a_s == WINS_TGT) begin
                        state_s  = ST_DONE;
                        winner_s = WIN_A;
                    end else if (score_b_s == WINS_TGT) begin
                        state_s  = ST_DONE;
                        winner_s = WIN_B;
                    end else if (round_count_s == ROUND_CAP) begin
                        state_s = ST_DONE;
                        if (score_a_s > score_b_s) begin
                            winner_s = WIN_A;
                        end else if (score_b_s > score_a_s) begin
                            winner_s = WIN_B;
                        end else begin
                            winner_s = WIN_DRAW;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s       = ST_PLAY;
                    score_a_s     = SCORE_W'(0);
                    score_b_s     = SCORE_W'(0);
                    round_count_s = RND_W'(0);
                    winner_s      = WIN_NONE;
                    result_err_s  = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                score_a_s     = SCORE_W'(0);
                score_b_s     = SCORE_W'(0);
                round_count_s = RND_W'(0);
                winner_s      = WIN_NONE;
                result_err_s  = 1'b0;
            end
        endcase

        round_ready_s = (state_s == ST_PLAY);
        match_over_s  = (state_s == ST_DONE);
    end

    // State, counters and all output flags are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            score_a_r     <= SCORE_W'(0);
            score_b_r     <= SCORE_W'(0);
            round_count_r <= RND_W'(0);
            winner_r      <= WIN_NONE;
            result_err_r  <= 1'b0;
            round_ready_r <= 1'b0;
            match_over_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            score_a_r     <= score_a_s;
            score_b_r     <= score_b_s;
            round_count_r <= round_count_s;
            winner_r      <= winner_s;
            result_err_r  <= result_err_s;
            round_ready_r <= round_ready_s;
            match_over_r  <= match_over_s;
        end
    end

    assign round_ready = round_ready_r;
    assign score_a     = score_a_r;
    assign score_b     = score_b_r;
    assign round_count = round_count_r;
    assign match_over  = match_over_r;
    assign winner      = winner_r;
    assign result_err  = result_err_r;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Scoreboard bench for rps_match_ctrl: every driven cycle pushes the
// expected post-edge output snapshot from a behavioural match model; the
// snapshot is popped and compared one time unit after the clock edge.
module tb_rps_match_ctrl;

    localparam int WN = 3;
    localparam int MR = 9;

    typedef struct {
        int sa;
        int sb;
        int rc;
        int over;
        int ready;
        int win;
        int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       round_valid = 1'b0;
    logic       player_a_wins = 1'b0;
    logic       player_b_wins = 1'b0;
    logic       tie_game = 1'b0;
    logic       round_ready;
    logic [2:0] score_a;
    logic [2:0] score_b;
    logic [3:0] round_count;
    logic       match_over;
    logic [1:0] winner;
    logic       result_err;

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];

    // Model state: 0 idle, 1 play, 2 done.
    int m_st = 0;
    int m_sa = 0;
    int m_sb = 0;
    int m_rc = 0;
    int m_win = 0;
    int m_err = 0;

    rps_match_ctrl #(
        .WINS_NEEDED (WN),
        .MAX_ROUNDS  (MR),
        .SCORE_W     (3),
        .RND_W       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .round_valid   (round_valid),
        .player_a_wins (player_a_wins),
        .player_b_wins (player_b_wins),
        .tie_game      (tie_game),
        .round_ready   (round_ready),
        .score_a       (score_a),
        .score_b       (score_b),
        .round_count   (round_count),
        .match_over    (match_over),
        .winner        (winner),
        .result_err    (result_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        m_sa = 0; m_sb = 0; m_rc = 0; m_win = 0; m_err = 0;
    endtask

    task automatic model_step(input bit st, input bit v, input bit a, input bit b, input bit t);
        if (st) begin
            model_clear();
            m_st = 1;
        end else if (m_st == 1 && v) begin
            if ((int'(a) + int'(b) + int'(t)) != 1) begin
                m_err = 1;
            end else begin
                if (a) m_sa++;
                if (b) m_sb++;
                m_rc++;
                if (m_sa == WN) begin
                    m_st = 2; m_win = 1;
                end else if (m_sb == WN) begin
                    m_st = 2; m_win = 2;
                end else if (m_rc == MR) begin
                    m_st = 2;
                    m_win = (m_sa > m_sb) ? 1 : ((m_sb > m_sa) ? 2 : 3);
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.sa = m_sa; e.sb = m_sb; e.rc = m_rc;
        e.over = (m_st == 2) ? 1 : 0;
        e.ready = (m_st == 1) ? 1 : 0;
        e.win = m_win; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_score_a"}, 32'(score_a), 32'(e.sa));
            check_val({tag, "_score_b"}, 32'(score_b), 32'(e.sb));
            check_val({tag, "_round_count"}, 32'(round_count), 32'(e.rc));
            check_val({tag, "_match_over"}, 32'(match_over), 32'(e.over));
            check_val({tag, "_round_ready"}, 32'(round_ready), 32'(e.ready));
            check_val({tag, "_winner"}, 32'(winner), 32'(e.win));
            check_val({tag, "_result_err"}, 32'(result_err), 32'(e.err));
        end
    endtask

    // One clock cycle of stimulus: drive, predict, clock, compare.
    task automatic drive(input string tag, input bit st, input bit v, input bit a, input bit b, input bit t);
        start = st; round_valid = v;
        player_a_wins = a; player_b_wins = b; tie_game = t;
        model_step(st, v, a, b, t);
        push_expected();
        @(posedge clk);
        #1;
        compare_outputs(tag);
        start = 1'b0; round_valid = 1'b0;
        player_a_wins = 1'b0; player_b_wins = 1'b0; tie_game = 1'b0;
    endtask

    task automatic rnd(input string tag, input int kind);
        // kind: 0 A, 1 B, 2 tie
        drive(tag, 1'b0, 1'b1, kind == 0, kind == 1, kind == 2);
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        #3;
        model_clear(); m_st = 0;
        push_expected();
        compare_outputs("reset");
        #9 rst_n = 1'b1;

        // Rounds in IDLE are ignored.
        rnd("idle_a", 0);
        drive("idle_bad", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // A,A,A: first-to-three for A.
        drive("m1_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rnd("m1_a", 0);
        drive("m1_done_round", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive("m1_done_bad", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // B,tie,A,B,tie,B: B takes it on round six.
        drive("m2_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m2_r1", 1); rnd("m2_r2", 2); rnd("m2_r3", 0);
        rnd("m2_r4", 1); rnd("m2_r5", 2); rnd("m2_r6", 1);

        // Cap at 2/2 -> draw.
        drive("m3_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m3_a", 0); rnd("m3_b", 1); rnd("m3_a", 0); rnd("m3_b", 1);
        for (int i = 0; i < 5; i++) rnd("m3_tie", 2);

        // Cap at 2/1 -> A.
        drive("m4_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m4_a", 0); rnd("m4_b", 1); rnd("m4_a", 0);
        for (int i = 0; i < 6; i++) rnd("m4_tie", 2);

        // Threshold win on the capped round.
        drive("m5_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m5_a", 0); rnd("m5_b", 1); rnd("m5_a", 0); rnd("m5_b", 1);
        for (int i = 0; i < 4; i++) rnd("m5_tie", 2);
        rnd("m5_final_a", 0);

        // Malformed rounds: error sticks, counters frozen, good round counted.
        drive("m6_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m6_a", 0);
        drive("m6_ab", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive("m6_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("m6_all", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive("m6_novalid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        rnd("m6_b", 1);
        drive("m6_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // start with a winning round at score 2: restart, no win recorded.
        rnd("m7_a", 0); rnd("m7_a", 0);
        drive("m7_start_win", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rnd("m7_b", 1);

        // Asynchronous reset mid-match at 2/1.
        drive("m8_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m8_a", 0); rnd("m8_b", 1); rnd("m8_a", 0);
        #2 rst_n = 1'b0;
        #1;
        model_clear(); m_st = 0;
        push_expected();
        compare_outputs("async_reset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rnd("m8_idle_a", 0);
        rnd("m8_idle_b", 1);
        drive("m9_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rnd("m9_a", 0);

        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
